demux3_dispatch: RTL

//  1-to-3 routing stage; inverse of the datapath's 3-input select mux. Accepts a WIDTH-bit

---
 rtl/demux3_pkg.sv | 14 +
 rtl/demux3_dispatch_if.sv | 28 ++
 rtl/demux3_slot.sv | 42 ++++
 rtl/demux3_dispatch.sv | 70 +++++++
 4 files changed

// File: rtl/demux3_pkg.sv
// rtl/demux3_pkg.sv - route codes and slot state encoding for the 1-to-3 dispatch stage
package demux3_pkg;

    localparam logic [1:0] ROUTE_P0   = 2'd0;
    localparam logic [1:0] ROUTE_P1   = 2'd1;
    localparam logic [1:0] ROUTE_P2   = 2'd2;
    localparam logic [1:0] ROUTE_DROP = 2'd3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux3_dispatch_if.sv
// rtl/demux3_dispatch_if.sv - input word stream plus three output port handshakes
interface demux3_dispatch_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic             out_valid0;
    logic             out_valid1;
    logic             out_valid2;
    logic             out_ready0;
    logic             out_ready1;
    logic             out_ready2;

    modport master (
        output in_data, in_sel, in_valid, out_ready0, out_ready1, out_ready2,
        input  in_ready, out_data0, out_data1, out_data2, out_valid0, out_valid1, out_valid2
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready0, out_ready1, out_ready2,
        output in_ready, out_data0, out_data1, out_data2, out_valid0, out_valid1, out_valid2
    );
endinterface

// File: rtl/demux3_slot.sv
// rtl/demux3_slot.sv - one-entry output register stage with valid/ready drain
module demux3_slot
    import demux3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             free
);

    slot_state_t state, state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SLOT_EMPTY;
        else       state <= state_next;
    end

    // A load while draining keeps the slot full, giving one word per cycle.
    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: if (load) state_next = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !load) state_next = SLOT_EMPTY;
            default:    state_next = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     out_data <= '0;
        else if (load) out_data <= data_in;
    end

    assign out_valid = (state == SLOT_FULL);
    assign free      = !out_valid || out_ready;

endmodule

// File: rtl/demux3_dispatch.sv
// rtl/demux3_dispatch.sv - 1-to-3 routing stage with null route; DEMUX3_DROP_CNT_EN builds the drop counter
module demux3_dispatch
    import demux3_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    demux3_dispatch_if.slave  bus,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic [2:0] free;
    logic [2:0] load;
    logic       ready_c;
    logic       accept;

    // Ready depends only on the selected slot, never on in_valid.
    always_comb begin
        ready_c = 1'b1;
        case (bus.in_sel)
            ROUTE_P0:   ready_c = free[0];
            ROUTE_P1:   ready_c = free[1];
            ROUTE_P2:   ready_c = free[2];
            ROUTE_DROP: ready_c = 1'b1;
            default:    ready_c = 1'b1;
        endcase
    end

    assign bus.in_ready = ready_c;
    assign accept       = bus.in_valid && ready_c;
    assign load[0]      = accept && (bus.in_sel == ROUTE_P0);
    assign load[1]      = accept && (bus.in_sel == ROUTE_P1);
    assign load[2]      = accept && (bus.in_sel == ROUTE_P2);

    demux3_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk(clk), .reset(reset), .load(load[0]), .data_in(bus.in_data),
        .out_data(bus.out_data0), .out_valid(bus.out_valid0),
        .out_ready(bus.out_ready0), .free(free[0])
    );

    demux3_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk(clk), .reset(reset), .load(load[1]), .data_in(bus.in_data),
        .out_data(bus.out_data1), .out_valid(bus.out_valid1),
        .out_ready(bus.out_ready1), .free(free[1])
    );

    demux3_slot #(.WIDTH(WIDTH)) u_slot2 (
        .clk(clk), .reset(reset), .load(load[2]), .data_in(bus.in_data),
        .out_data(bus.out_data2), .out_valid(bus.out_valid2),
        .out_ready(bus.out_ready2), .free(free[2])
    );

`ifdef DEMUX3_DROP_CNT_EN
    logic drop_accept;
    assign drop_accept = accept && (bus.in_sel == ROUTE_DROP);

    // Saturating: the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt <= '0;
        else if (drop_accept && (drop_cnt != {CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + 1'b1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule
